output_port_arbiter: RTL and testbench



---
 rtl/output_port_arbiter_pkg.sv | 20 ++
 rtl/output_port_arbiter_rr_pick.sv | 50 +++++
 rtl/output_port_arbiter.sv | 129 ++++++++++++
 tb/tb_output_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// output_port_arbiter_pkg
// Shared router constants for the per-output-port arbiter.
// Contents:
//   NREQ_DEF      - number of requesting input buffers. It equals the
//                   priority decider's PRIOWIDTH.
//   DATAWIDTH_DEF - flit width in bits.
//   arb_state_t   - arbiter state type, with constants ST_IDLE and ST_XFER.
// -----------------------------------------------------------------------------
package output_port_arbiter_pkg;

    localparam int NREQ_DEF      = 4;
    localparam int DATAWIDTH_DEF = 32;

    typedef logic [0:0] arb_state_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

endpackage

// File: rtl/output_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// output_port_arbiter_rr_pick
// Combinational rotating-priority picker. It is reusable by every output port.
// Ports:
//   req          in  [NREQ] - request vector
//   priority_val in  [NREQ] - one-hot start position.
//                             If several bits are set, the lowest set bit is used.
//                             If no bit is set, the start position is 0.
//   winner       out [NREQ] - one-hot winner, or 0 when req is 0
//   contested    out        - two or more requesters are active
// -----------------------------------------------------------------------------
module output_port_arbiter_rr_pick
    import output_port_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] priority_val,
    output logic [NREQ-1:0] winner,
    output logic            contested
);

    localparam logic [NREQ-1:0] LSB_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    logic [NREQ-1:0] prio_low_s;
    logic [NREQ-1:0] ge_mask_s;
    logic [NREQ-1:0] upper_s;
    logic [NREQ-1:0] lower_s;

    // x & -x isolates the lowest set bit. This also makes a malformed
    // priority vector resolve to its lowest set bit.
    assign prio_low_s = priority_val & (~priority_val + LSB_ONE);

    // Mask of positions at or above the start index. With no priority bit
    // set, the start index is 0, so every position qualifies.
    assign ge_mask_s  = (|priority_val) ? ~(prio_low_s - LSB_ONE) : {NREQ{1'b1}};

    // The scan runs start..NREQ-1 first, then wraps to 0..start-1.
    // Each half therefore resolves to its own lowest set bit.
    assign upper_s    = req & ge_mask_s;
    assign lower_s    = req & ~ge_mask_s;

    assign winner     = (|upper_s) ? (upper_s & (~upper_s + LSB_ONE))
                                   : (lower_s & (~lower_s + LSB_ONE));

    // Clearing the lowest set bit leaves a non-zero value only if a second
    // requester exists.
    assign contested  = |(req & (req - LSB_ONE));

endmodule

// File: rtl/output_port_arbiter.sv
// -----------------------------------------------------------------------------
// output_port_arbiter
// Per-output-port packet arbiter. NREQ input buffers share one output buffer.
// A winner is chosen from the rotating priority vector. The winner keeps the
// grant from the head flit through the tail flit.
// Ports:
//   clk          in                   - clock, rising edge
//   reset        in                   - asynchronous, active-low reset
//   req          in  [NREQ]           - input buffer i non-empty and targeting this port
//   in_data      in  [NREQ*DATAWIDTH] - front flit of each input buffer
//   in_tail      in  [NREQ]           - front flit of buffer i is a packet tail
//   out_full     in                   - output buffer cannot accept a flit
//   priority_val in  [NREQ]           - one-hot highest-priority requester
//   change_prio  out                  - registered pulse that rotates the priority
//   grant        out [NREQ]           - registered one-hot owner, 0 when idle
//   pop          out [NREQ]           - combinational dequeue strobe
//   out_data     out [DATAWIDTH]      - registered flit to the output buffer
//   out_valid    out                  - registered write strobe
// -----------------------------------------------------------------------------
module output_port_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] in_data,
    input  logic [NREQ-1:0]           in_tail,
    input  logic                      out_full,
    input  logic [NREQ-1:0]           priority_val,
    output logic                      change_prio,
    output logic [NREQ-1:0]           grant,
    output logic [NREQ-1:0]           pop,
    output logic [DATAWIDTH-1:0]      out_data,
    output logic                      out_valid
);

    arb_state_t           state_r;
    logic [NREQ-1:0]      grant_r;
    logic                 change_prio_r;
    logic [DATAWIDTH-1:0] out_data_r;
    logic                 out_valid_r;

    logic [NREQ-1:0]      winner_s;
    logic                 contested_s;
    logic                 g_req_s;
    logic                 g_tail_s;
    logic                 do_pop_s;
    logic [DATAWIDTH-1:0] g_data_s;

    output_port_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req          (req),
        .priority_val (priority_val),
        .winner       (winner_s),
        .contested    (contested_s)
    );

    // AND-OR mux of the granted buffer's front flit. grant_r is one-hot or 0.
    always_comb begin
        g_data_s = {DATAWIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            g_data_s = g_data_s | (in_data[i*DATAWIDTH +: DATAWIDTH] & {DATAWIDTH{grant_r[i]}});
        end
    end

    assign g_req_s  = |(req & grant_r);
    assign g_tail_s = |(in_tail & grant_r);

    // A pop needs the owner's buffer to be non-empty and room downstream.
    // An underrun or backpressure simply stalls with the grant held.
    assign do_pop_s = (state_r == ST_XFER) && g_req_s && !out_full;
    assign pop      = do_pop_s ? grant_r : {NREQ{1'b0}};

    // Arbitration / transfer state machine with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            grant_r       <= {NREQ{1'b0}};
            change_prio_r <= 1'b0;
            out_data_r    <= {DATAWIDTH{1'b0}};
            out_valid_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_valid_r <= 1'b0;
                    if (|req) begin
                        grant_r       <= winner_s;
                        change_prio_r <= contested_s;
                        state_r       <= ST_XFER;
                    end else begin
                        grant_r       <= {NREQ{1'b0}};
                        change_prio_r <= 1'b0;
                    end
                end
                ST_XFER: begin
                    change_prio_r <= 1'b0;
                    if (do_pop_s) begin
                        out_data_r  <= g_data_s;
                        out_valid_r <= 1'b1;
                        if (g_tail_s) begin
                            grant_r <= {NREQ{1'b0}};
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_XFER;
                        end
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    grant_r       <= {NREQ{1'b0}};
                    change_prio_r <= 1'b0;
                    out_valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign change_prio = change_prio_r;
    assign grant       = grant_r;
    assign out_data    = out_data_r;
    assign out_valid   = out_valid_r;

endmodule

// File: tb/tb_output_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_output_port_arbiter
// Self-checking bench for output_port_arbiter. A packet-level reference model
// tracks the current owner index. Its winner is found by a modulo scan from
// the priority index, and contention is found by counting requesters. Every
// cycle the model is compared with pop, grant, change_prio, out_valid and
// out_data. Directed scenarios add fixed expected values.
// -----------------------------------------------------------------------------
module tb_output_port_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic              clk          = 1'b0;
    logic              reset        = 1'b0;
    logic [NREQ-1:0]   req          = 4'b0000;
    logic [NREQ*DW-1:0] in_data     = 128'd0;
    logic [NREQ-1:0]   in_tail      = 4'b0000;
    logic              out_full     = 1'b0;
    logic [NREQ-1:0]   priority_val = 4'b0001;
    logic              change_prio;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   pop;
    logic [DW-1:0]     out_data;
    logic              out_valid;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_owner = -1;
    logic        m_cp    = 1'b0;
    logic        m_ov    = 1'b0;
    logic [31:0] m_od    = 32'd0;

    output_port_arbiter #(
        .NREQ      (NREQ),
        .DATAWIDTH (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .in_data      (in_data),
        .in_tail      (in_tail),
        .out_full     (out_full),
        .priority_val (priority_val),
        .change_prio  (change_prio),
        .grant        (grant),
        .pop          (pop),
        .out_data     (out_data),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner index: scan from the priority index p, modulo 4.
    // p is the lowest set bit of pv, or 0 when pv is 0.
    function automatic int ref_pick(input logic [3:0] r, input logic [3:0] pv);
        int p = 0;
        for (int i = 0; i < 4; i++) begin
            if (pv[i]) begin
                p = i;
                break;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic int ref_count(input logic [3:0] r);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(r[i]);
        return n;
    endfunction

    function automatic logic [3:0] ref_grant();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    function automatic logic [3:0] ref_pop();
        if (m_owner >= 0 && reset && req[m_owner] && !out_full) return 4'(1 << m_owner);
        return 4'b0000;
    endfunction

    task automatic model_clear();
        m_owner = -1;
        m_cp    = 1'b0;
        m_ov    = 1'b0;
        m_od    = 32'd0;
    endtask

    // Advance the model across one rising edge, using the inputs present at that edge.
    task automatic model_update();
        if (!reset) begin
            model_clear();
        end else if (m_owner < 0) begin
            m_ov = 1'b0;
            if (req != 4'b0000) begin
                m_owner = ref_pick(req, priority_val);
                m_cp    = (ref_count(req) >= 2);
            end else begin
                m_cp = 1'b0;
            end
        end else begin
            m_cp = 1'b0;
            if (req[m_owner] && !out_full) begin
                m_ov = 1'b1;
                m_od = in_data[m_owner*DW +: DW];
                if (in_tail[m_owner]) m_owner = -1;
            end else begin
                m_ov = 1'b0;
            end
        end
    endtask

    // Check pop before the edge, then the registered outputs just after the edge.
    task automatic step();
        #1;
        chk("pop", 32'(pop), 32'(ref_pop()));
        @(posedge clk);
        model_update();
        #1;
        chk("grant", 32'(grant), 32'(ref_grant()));
        chk("change_prio", 32'(change_prio), 32'(m_cp));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) chk("out_data", out_data, m_od);
    endtask

    task automatic drv(input logic [3:0] r, input logic [3:0] pv, input logic [3:0] t, input logic f);
        req          = r;
        priority_val = pv;
        in_tail      = t;
        out_full     = f;
        in_data      = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic set_flit(input int i, input logic [31:0] v);
        in_data[i*DW +: DW] = v;
    endtask

    // Drop reset between edges; the outputs must clear without waiting for a clock edge.
    task automatic async_reset();
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_change_prio", 32'(change_prio), 32'h0);
    endtask

    initial begin
        model_clear();

        // Reset held low with every input requesting
        drv(4'b1111, 4'b0001, 4'b1111, 1'b0);
        step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_pop", 32'(pop), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        reset = 1'b1;
        step();
        chk("rel_grant", 32'(grant), 32'h1);
        chk("rel_change_prio", 32'(change_prio), 32'h1);
        step();
        chk("rel_tail_grant", 32'(grant), 32'h0);
        chk("rel_cp_low", 32'(change_prio), 32'h0);
        drv(4'b0000, 4'b0001, 4'b0000, 1'b0);
        step();

        // Round robin, including the wrap from index 3 to index 0
        drv(4'b1010, 4'b0100, 4'b1111, 1'b0);
        step();
        chk("rr_grant", 32'(grant), 32'h8);
        chk("rr_change_prio", 32'(change_prio), 32'h1);
        step();
        drv(4'b0011, 4'b1000, 4'b1111, 1'b0);
        step();
        chk("rr_wrap_grant", 32'(grant), 32'h1);
        step();
        drv(4'b0000, 4'b1000, 4'b0000, 1'b0);
        step();

        // A single requester must not pulse change_prio
        drv(4'b0100, 4'b0001, 4'b0100, 1'b0);
        step();
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_cp", 32'(change_prio), 32'h0);
        step();
        drv(4'b0000, 4'b0001, 4'b0000, 1'b0);
        step();

        // Three-flit packet from buffer 1 while buffer 2 also requests
        drv(4'b0110, 4'b0010, 4'b0000, 1'b0);
        step();
        chk("mf_grant", 32'(grant), 32'h2);
        set_flit(1, 32'hF100_0001);
        step();
        chk("mf_flit1", out_data, 32'hF100_0001);
        set_flit(1, 32'hF100_0002);
        step();
        chk("mf_flit2", out_data, 32'hF100_0002);
        chk("mf_hold", 32'(grant), 32'h2);
        in_tail = 4'b0010;
        set_flit(1, 32'hF100_0003);
        step();
        chk("mf_flit3", out_data, 32'hF100_0003);
        chk("mf_gap", 32'(grant), 32'h0);
        drv(4'b0100, 4'b0010, 4'b0100, 1'b0);
        step();
        chk("mf_next", 32'(grant), 32'h4);
        step();
        drv(4'b0000, 4'b0010, 4'b0000, 1'b0);
        step();

        // Backpressure for two cycles, then a one-cycle source underrun
        drv(4'b0001, 4'b0001, 4'b0000, 1'b0);
        step();
        set_flit(0, 32'hA000_0001);
        step();
        chk("bp_first", out_data, 32'hA000_0001);
        for (int k = 0; k < 2; k++) begin
            drv(4'b0001, 4'b0001, 4'b0000, 1'b1);
            #1;
            chk("bp_pop", 32'(pop), 32'h0);
            step();
            chk("bp_ov", 32'(out_valid), 32'h0);
            chk("bp_grant", 32'(grant), 32'h1);
        end
        drv(4'b0000, 4'b0001, 4'b0000, 1'b0);
        step();
        chk("ur_ov", 32'(out_valid), 32'h0);
        chk("ur_grant", 32'(grant), 32'h1);
        drv(4'b0001, 4'b0001, 4'b0001, 1'b0);
        set_flit(0, 32'hA000_0002);
        step();
        chk("ur_last", out_data, 32'hA000_0002);
        chk("ur_end", 32'(grant), 32'h0);
        drv(4'b0000, 4'b0001, 4'b0000, 1'b0);
        step();

        // Asynchronous reset in the middle of a packet
        drv(4'b0011, 4'b0001, 4'b0000, 1'b0);
        step();
        step();
        async_reset();
        step();
        reset = 1'b1;
        drv(4'b0010, 4'b0001, 4'b0010, 1'b0);
        step();
        chk("post_rst_grant", 32'(grant), 32'h2);
        chk("post_rst_cp", 32'(change_prio), 32'h0);
        step();
        drv(4'b0000, 4'b0001, 4'b0000, 1'b0);
        step();

        // Random traffic, including malformed priority vectors and occasional resets
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] r;
            logic [3:0] pv;
            r  = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
            pv = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            drv(r, pv, 4'($urandom) & 4'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
